// File: rtl/dice_roller.sv
// dice_roller: two-die generator for the Craps datapath.
// Tumbles the displayed dice while the roll button is held, latches a final
// pair on release, and reports sum/valid to the game controller.
// Build option: define DICE_LFSR_EN to step die 2 from a 16-bit LFSR instead
// of on the die 1 wrap.
module dice_roller #(
   parameter int unsigned MIN_ROLL_CYCLES = 16,
   parameter int unsigned TUMBLE_DIV      = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       roll,
   input  logic       enable,
   output logic [3:0] dice1,
   output logic [3:0] dice2,
   output logic [3:0] sum,
   output logic       update,
   output logic       valid,
   output logic       busy
);

   typedef enum logic {IDLE = 1'b0, ROLL = 1'b1} state_t;

   localparam logic [7:0] MIN_CNT     = 8'(MIN_ROLL_CYCLES);
   localparam logic [7:0] TUMBLE_LAST = 8'(TUMBLE_DIV - 1);

   logic       s1, s2, s3;
   logic       rise;
   logic [2:0] c1, c2;
   logic       c2_step;

   state_t     state_reg, state_next;
   logic [7:0] roll_cnt_reg, roll_cnt_next;
   logic [7:0] tumble_reg, tumble_next;
   logic [3:0] dice1_next, dice2_next, sum_next;
   logic       update_next, valid_next, busy_next;

   // Two-flop synchroniser for the raw button plus a history stage for edge detect.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= roll;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

`ifdef DICE_LFSR_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR (taps 16,14,13,11) decides when die 2 advances.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign c2_step = lfsr[0];
`else
   assign c2_step = (c1 == 3'd6);
`endif

   // Free-running 1..6 generators; die 2 advances only when c2_step is set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         c1 <= 3'd1;
         c2 <= 3'd1;
      end else begin
         c1 <= (c1 == 3'd6) ? 3'd1 : c1 + 3'd1;
         if (c2_step) begin
            c2 <= (c2 == 3'd6) ? 3'd1 : c2 + 3'd1;
         end
      end
   end

   // Next-state and next-output logic; abort beats final latch beats tumble.
   always_comb begin
      state_next    = state_reg;
      roll_cnt_next = roll_cnt_reg;
      tumble_next   = tumble_reg;
      dice1_next    = dice1;
      dice2_next    = dice2;
      sum_next      = sum;
      update_next   = 1'b0;
      valid_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rise && enable) begin
               state_next    = ROLL;
               roll_cnt_next = 8'd0;
               tumble_next   = 8'd0;
               sum_next      = 4'd0;
            end
         end
         ROLL: begin
            if (!enable) begin
               state_next  = IDLE;
               dice1_next  = 4'd0;
               dice2_next  = 4'd0;
               update_next = 1'b1;
            end else if ((roll_cnt_reg == MIN_CNT) && !s2) begin
               state_next  = IDLE;
               dice1_next  = {1'b0, c1};
               dice2_next  = {1'b0, c2};
               sum_next    = {1'b0, c1} + {1'b0, c2};
               valid_next  = 1'b1;
               update_next = 1'b1;
            end else begin
               if (roll_cnt_reg < MIN_CNT) begin
                  roll_cnt_next = roll_cnt_reg + 8'd1;
               end
               if (tumble_reg >= TUMBLE_LAST) begin
                  tumble_next = 8'd0;
                  dice1_next  = {1'b0, c1};
                  dice2_next  = {1'b0, c2};
                  update_next = 1'b1;
               end else begin
                  tumble_next = tumble_reg + 8'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next == ROLL);
   end

   // State, counters and all outputs are registered here.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         roll_cnt_reg <= 8'd0;
         tumble_reg   <= 8'd0;
         dice1        <= 4'd0;
         dice2        <= 4'd0;
         sum          <= 4'd0;
         update       <= 1'b0;
         valid        <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_reg    <= state_next;
         roll_cnt_reg <= roll_cnt_next;
         tumble_reg   <= tumble_next;
         dice1        <= dice1_next;
         dice2        <= dice2_next;
         sum          <= sum_next;
         update       <= update_next;
         valid        <= valid_next;
         busy         <= busy_next;
      end
   end

endmodule
